// File: rtl/hazard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
// Shared definitions for the miniLA pipeline hazard/flow controller:
//   - register index width
//   - operand-forwarding select encodings
//   - controller FSM state encodings
//   - in-flight writer tag record and the tag/source match helper
// -----------------------------------------------------------------------------
package hazard_pkg;

  localparam int REG_IDX_W = 5;

  // ID operand source selects
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b11;

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_LU_STALL = 2'b01,
    ST_FLUSH    = 2'b10,
    ST_FREEZE   = 2'b11
  } state_t;

  // One in-flight register writer
  typedef struct packed {
    logic                 valid;
    logic [REG_IDX_W-1:0] rd;
    logic                 is_load;
  } tag_t;

  localparam tag_t TAG_NONE = '{valid: 1'b0, rd: 5'd0, is_load: 1'b0};

  // A source hits a tag only if it is really read, is not r0, and the tag
  // holds a live writer of that same register.
  function automatic logic tag_hit(input tag_t tag,
                                   input logic [REG_IDX_W-1:0] src,
                                   input logic src_use);
    return src_use && (src != 5'd0) && tag.valid && (tag.rd == src);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl_if
// Bundle between the pipeline datapath (master) and the hazard controller
// (slave).
//   master drives : id_valid, rj_ID, rk_ID, rj_use_ID, rk_use_ID, rd_ID,
//                   wb_ena_ID, is_load_ID, redirect_EX, bus_wait
//   slave drives  : pc_hold, ifid_hold, ifid_clr, idex_clr, exmem_hold,
//                   memwb_hold, fwd_j, fwd_k, ctrl_state
// -----------------------------------------------------------------------------
interface pipe_hazard_ctrl_if;
  import hazard_pkg::*;

  logic                 id_valid;
  logic [REG_IDX_W-1:0] rj_ID;
  logic [REG_IDX_W-1:0] rk_ID;
  logic                 rj_use_ID;
  logic                 rk_use_ID;
  logic [REG_IDX_W-1:0] rd_ID;
  logic                 wb_ena_ID;
  logic                 is_load_ID;
  logic                 redirect_EX;
  logic                 bus_wait;

  logic                 pc_hold;
  logic                 ifid_hold;
  logic                 ifid_clr;
  logic                 idex_clr;
  logic                 exmem_hold;
  logic                 memwb_hold;
  logic [1:0]           fwd_j;
  logic [1:0]           fwd_k;
  logic [1:0]           ctrl_state;

  modport master (
    output id_valid, rj_ID, rk_ID, rj_use_ID, rk_use_ID, rd_ID,
           wb_ena_ID, is_load_ID, redirect_EX, bus_wait,
    input  pc_hold, ifid_hold, ifid_clr, idex_clr, exmem_hold, memwb_hold,
           fwd_j, fwd_k, ctrl_state
  );

  modport slave (
    input  id_valid, rj_ID, rk_ID, rj_use_ID, rk_use_ID, rd_ID,
           wb_ena_ID, is_load_ID, redirect_EX, bus_wait,
    output pc_hold, ifid_hold, ifid_clr, idex_clr, exmem_hold, memwb_hold,
           fwd_j, fwd_k, ctrl_state
  );

endinterface

// File: rtl/fwd_match.sv
// -----------------------------------------------------------------------------
// fwd_match
// Pure comparator for one ID source operand against the three in-flight
// writer tags. The youngest matching writer wins (EX > MEM > WB > RF).
// A match against a load still in EX cannot forward (data not yet
// available) and is reported as a load-use hazard instead.
// Ports:
//   src_idx, src_use          : source register index and its read enable
//   tag_ex, tag_mem, tag_wb   : in-flight writer tags
//   fwd_sel                   : operand source select
//   load_use                  : load in EX feeds this operand
// -----------------------------------------------------------------------------
module fwd_match
  import hazard_pkg::*;
(
  input  logic [REG_IDX_W-1:0] src_idx,
  input  logic                 src_use,
  input  tag_t                 tag_ex,
  input  tag_t                 tag_mem,
  input  tag_t                 tag_wb,
  output logic [1:0]           fwd_sel,
  output logic                 load_use
);

  // Priority compare, youngest writer first
  always_comb begin
    fwd_sel  = FWD_RF;
    load_use = 1'b0;
    if (tag_hit(tag_ex, src_idx, src_use)) begin
      if (tag_ex.is_load) begin
        fwd_sel  = FWD_RF;
        load_use = 1'b1;
      end else begin
        fwd_sel  = FWD_EX;
        load_use = 1'b0;
      end
    end else if (tag_hit(tag_mem, src_idx, src_use)) begin
      fwd_sel = FWD_MEM;
    end else if (tag_hit(tag_wb, src_idx, src_use)) begin
      fwd_sel = FWD_WB;
    end else begin
      fwd_sel = FWD_RF;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
// Hazard and flow controller for the miniLA 5-stage pipeline. Keeps its own
// EX/MEM/WB writer-tag pipeline, generates ID forwarding selects, and drives
// load-use stalls, redirect flushes and bus-wait freezes.
// Ports:
//   cpu_clk  : pipeline clock
//   cpu_rst  : asynchronous active-low reset
//   hz       : pipe_hazard_ctrl_if.slave (ID info, redirect, bus_wait in;
//              hold/clear, forwarding selects and FSM state out)
// Optional build macro PIPE_HAZARD_PERF_EN adds saturating 32-bit counters
//   perf_stall_cnt / perf_flush_cnt / perf_freeze_cnt (cycles spent in
//   LU_STALL / FLUSH / FREEZE).
// Hold/clear and forwarding outputs are combinational on the current inputs
// and tags so the pipeline registers see them in the same cycle; ctrl_state
// is the registered state and therefore trails those outputs by one cycle.
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl
  import hazard_pkg::*;
(
  input  logic                cpu_clk,
  input  logic                cpu_rst,
  pipe_hazard_ctrl_if.slave   hz
`ifdef PIPE_HAZARD_PERF_EN
  ,
  output logic [31:0]         perf_stall_cnt,
  output logic [31:0]         perf_flush_cnt,
  output logic [31:0]         perf_freeze_cnt
`endif
);

  state_t     state_r;
  state_t     next_state_s;
  tag_t       tag_ex_r;
  tag_t       tag_mem_r;
  tag_t       tag_wb_r;
  logic [1:0] fwd_j_s;
  logic [1:0] fwd_k_s;
  logic       lu_j_s;
  logic       lu_k_s;
  logic       lu_hazard_s;
  logic       idex_clr_s;

  fwd_match u_fwd_j (
    .src_idx  (hz.rj_ID),
    .src_use  (hz.rj_use_ID),
    .tag_ex   (tag_ex_r),
    .tag_mem  (tag_mem_r),
    .tag_wb   (tag_wb_r),
    .fwd_sel  (fwd_j_s),
    .load_use (lu_j_s)
  );

  fwd_match u_fwd_k (
    .src_idx  (hz.rk_ID),
    .src_use  (hz.rk_use_ID),
    .tag_ex   (tag_ex_r),
    .tag_mem  (tag_mem_r),
    .tag_wb   (tag_wb_r),
    .fwd_sel  (fwd_k_s),
    .load_use (lu_k_s)
  );

  assign lu_hazard_s = lu_j_s | lu_k_s;

  // FSM state register
  always_ff @(posedge cpu_clk or negedge cpu_rst) begin
    if (!cpu_rst) begin
      state_r <= ST_RUN;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next state: freeze beats redirect beats load-use. A redirect held under
  // freeze is seen again once bus_wait drops because EX is held too.
  always_comb begin
    next_state_s = ST_RUN;
    if (hz.bus_wait) begin
      next_state_s = ST_FREEZE;
    end else if (hz.redirect_EX) begin
      next_state_s = ST_FLUSH;
    end else if (lu_hazard_s) begin
      next_state_s = ST_LU_STALL;
    end else begin
      next_state_s = ST_RUN;
    end
  end

  // Hold/clear decode from the condition being entered this cycle
  always_comb begin
    hz.pc_hold    = 1'b0;
    hz.ifid_hold  = 1'b0;
    hz.ifid_clr   = 1'b0;
    hz.idex_clr   = 1'b0;
    hz.exmem_hold = 1'b0;
    hz.memwb_hold = 1'b0;
    hz.fwd_j      = FWD_RF;
    hz.fwd_k      = FWD_RF;
    hz.ctrl_state = state_r;
    idex_clr_s    = 1'b0;
    if (!cpu_rst) begin
      // Keep the datapath quiet while reset is asserted
      hz.ctrl_state = ST_RUN;
    end else begin
      hz.fwd_j = fwd_j_s;
      hz.fwd_k = fwd_k_s;
      case (next_state_s)
        ST_FREEZE: begin
          hz.pc_hold    = 1'b1;
          hz.ifid_hold  = 1'b1;
          hz.exmem_hold = 1'b1;
          hz.memwb_hold = 1'b1;
        end
        ST_FLUSH: begin
          hz.ifid_clr = 1'b1;
          hz.idex_clr = 1'b1;
          idex_clr_s  = 1'b1;
        end
        ST_LU_STALL: begin
          hz.pc_hold   = 1'b1;
          hz.ifid_hold = 1'b1;
          hz.idex_clr  = 1'b1;
          idex_clr_s   = 1'b1;
        end
        ST_RUN: begin
          hz.pc_hold = 1'b0;
        end
        default: begin
          hz.pc_hold = 1'b0;
        end
      endcase
    end
  end

  // Writer-tag pipeline: frozen on bus wait, bubble into EX on idex_clr
  always_ff @(posedge cpu_clk or negedge cpu_rst) begin
    if (!cpu_rst) begin
      tag_ex_r  <= TAG_NONE;
      tag_mem_r <= TAG_NONE;
      tag_wb_r  <= TAG_NONE;
    end else if (!hz.bus_wait) begin
      tag_wb_r  <= tag_mem_r;
      tag_mem_r <= tag_ex_r;
      if (idex_clr_s) begin
        tag_ex_r <= TAG_NONE;
      end else begin
        tag_ex_r <= '{valid:   hz.id_valid & hz.wb_ena_ID & (hz.rd_ID != 5'd0),
                      rd:      hz.rd_ID,
                      is_load: hz.is_load_ID};
      end
    end else begin
      tag_wb_r  <= tag_wb_r;
      tag_mem_r <= tag_mem_r;
      tag_ex_r  <= tag_ex_r;
    end
  end

`ifdef PIPE_HAZARD_PERF_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : (v + 32'd1);
  endfunction

  // Saturating per-state cycle counters
  always_ff @(posedge cpu_clk or negedge cpu_rst) begin
    if (!cpu_rst) begin
      perf_stall_cnt  <= 32'd0;
      perf_flush_cnt  <= 32'd0;
      perf_freeze_cnt <= 32'd0;
    end else begin
      perf_stall_cnt  <= (state_r == ST_LU_STALL) ? sat_inc(perf_stall_cnt)  : perf_stall_cnt;
      perf_flush_cnt  <= (state_r == ST_FLUSH)    ? sat_inc(perf_flush_cnt)  : perf_flush_cnt;
      perf_freeze_cnt <= (state_r == ST_FREEZE)   ? sat_inc(perf_freeze_cnt) : perf_freeze_cnt;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
// Directed bench for pipe_hazard_ctrl. Inputs change 1 ns after the rising
// edge; outputs are sampled 4 ns after the edge, well before the next one.
// ctl packs {pc_hold, ifid_hold, ifid_clr, idex_clr, exmem_hold, memwb_hold}.
// -----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

  localparam logic [5:0] CTL_NONE = 6'b000000;
  localparam logic [5:0] CTL_LU   = 6'b110100;
  localparam logic [5:0] CTL_FL   = 6'b001100;
  localparam logic [5:0] CTL_FZ   = 6'b110011;

  logic cpu_clk;
  logic cpu_rst;
  int   checks;
  int   errors;

  pipe_hazard_ctrl_if hz_if ();

`ifdef PIPE_HAZARD_PERF_EN
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_flush_cnt;
  logic [31:0] perf_freeze_cnt;
`endif

  pipe_hazard_ctrl dut (
    .cpu_clk         (cpu_clk),
    .cpu_rst         (cpu_rst),
    .hz              (hz_if)
`ifdef PIPE_HAZARD_PERF_EN
    ,
    .perf_stall_cnt  (perf_stall_cnt),
    .perf_flush_cnt  (perf_flush_cnt),
    .perf_freeze_cnt (perf_freeze_cnt)
`endif
  );

  initial cpu_clk = 1'b0;
  always #5 cpu_clk = ~cpu_clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] rj, input logic ju,
                       input logic [4:0] rk, input logic ku, input logic [4:0] rd,
                       input logic we, input logic ld, input logic rdr, input logic bw);
    hz_if.id_valid    = v;
    hz_if.rj_ID       = rj;
    hz_if.rj_use_ID   = ju;
    hz_if.rk_ID       = rk;
    hz_if.rk_use_ID   = ku;
    hz_if.rd_ID       = rd;
    hz_if.wb_ena_ID   = we;
    hz_if.is_load_ID  = ld;
    hz_if.redirect_EX = rdr;
    hz_if.bus_wait    = bw;
  endtask

  // Sample point inside the current cycle, then check all outputs
  task automatic expect_out(input string tag, input logic [5:0] ctl,
                            input logic [1:0] fj, input logic [1:0] fk, input logic [1:0] st);
    logic [5:0] ctl_obs;
    #3;
    ctl_obs = {hz_if.pc_hold, hz_if.ifid_hold, hz_if.ifid_clr,
               hz_if.idex_clr, hz_if.exmem_hold, hz_if.memwb_hold};
    check_val({tag, ".ctl"},   {26'd0, ctl_obs},          {26'd0, ctl});
    check_val({tag, ".fwd_j"}, {30'd0, hz_if.fwd_j},      {30'd0, fj});
    check_val({tag, ".fwd_k"}, {30'd0, hz_if.fwd_k},      {30'd0, fk});
    check_val({tag, ".state"}, {30'd0, hz_if.ctrl_state}, {30'd0, st});
  endtask

  task automatic tick;
    @(posedge cpu_clk);
    #1;
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    cpu_rst = 1'b0;
    // Freeze and redirect requests during reset must not reach the outputs
    drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, 1'b1, 1'b1);
    #1;
    expect_out("reset", CTL_NONE, 2'b00, 2'b00, 2'b00);
    #16 cpu_rst = 1'b1;
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();

    // A: add r5 enters EX next
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_out("A", CTL_NONE, 2'b00, 2'b00, 2'b00);
    tick();
    // B: r5 in EX; rk=r5 with use bit clear must not match
    drive(1'b1, 5'd5, 1'b1, 5'd5, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_out("B_ex_fwd", CTL_NONE, 2'b01, 2'b00, 2'b00);
    tick();
    // C: r5 in MEM, r7 in EX; this instruction writes r0
    drive(1'b1, 5'd5, 1'b1, 5'd7, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_out("C_mem_fwd", CTL_NONE, 2'b10, 2'b01, 2'b00);
    tick();
    // D: r0 writer in EX gives no match; r5 now in WB; ld r6 follows
    drive(1'b1, 5'd5, 1'b1, 5'd0, 1'b1, 5'd6, 1'b1, 1'b1, 1'b0, 1'b0);
    expect_out("D_wb_r0", CTL_NONE, 2'b11, 2'b00, 2'b00);
    tick();
    // E: load r6 in EX, consumer reads r6 -> one bubble
    drive(1'b1, 5'd6, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_out("E_lu", CTL_LU, 2'b00, 2'b00, 2'b00);
    tick();
    // F: same consumer, load now in MEM
    expect_out("F_lu_after", CTL_NONE, 2'b10, 2'b00, 2'b01);
    tick();
    // G: r8 in EX, load r6 in WB; ld r9 follows
    drive(1'b1, 5'd6, 1'b1, 5'd8, 1'b1, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0);
    expect_out("G_back_run", CTL_NONE, 2'b11, 2'b01, 2'b00);
    tick();
    // H: load-use on r9 together with redirect -> redirect wins
    drive(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    expect_out("H_redir_lu", CTL_FL, 2'b00, 2'b00, 2'b00);
    tick();
    // I: tag_EX was killed, so load r9 seen in MEM without a stall
    drive(1'b1, 5'd9, 1'b1, 5'd8, 1'b1, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_out("I_flush", CTL_NONE, 2'b10, 2'b11, 2'b10);
    tick();
    // J-L: bus_wait for 3 cycles with a pending redirect; r10 stays in EX
    drive(1'b1, 5'd10, 1'b1, 5'd0, 1'b0, 5'd11, 1'b1, 1'b0, 1'b1, 1'b1);
    expect_out("J_frz1", CTL_FZ, 2'b01, 2'b00, 2'b00);
    tick();
    expect_out("K_frz2", CTL_FZ, 2'b01, 2'b00, 2'b11);
    tick();
    expect_out("L_frz3", CTL_FZ, 2'b01, 2'b00, 2'b11);
    tick();
    // M: freeze lifts, redirect still pending -> flush
    drive(1'b1, 5'd10, 1'b1, 5'd0, 1'b0, 5'd11, 1'b1, 1'b0, 1'b1, 1'b0);
    expect_out("M_frz_exit", CTL_FL, 2'b01, 2'b00, 2'b11);
    tick();
    // N: r10 moved to MEM; ld r12 follows
    drive(1'b1, 5'd10, 1'b1, 5'd0, 1'b0, 5'd12, 1'b1, 1'b1, 1'b0, 1'b0);
    expect_out("N_post_flush", CTL_NONE, 2'b10, 2'b00, 2'b10);
    tick();
    // O: load-use on rk=r12
    drive(1'b1, 5'd10, 1'b1, 5'd12, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_out("O_lu_k", CTL_LU, 2'b11, 2'b00, 2'b00);
    tick();
    // P: in LU_STALL with the load tag live in MEM; then reset mid-stall
    drive(1'b1, 5'd0, 1'b0, 5'd12, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_out("P_stall", CTL_NONE, 2'b00, 2'b10, 2'b01);
    cpu_rst = 1'b0;
    #1;
    check_val("P_rst.state", {30'd0, hz_if.ctrl_state}, 32'd0);
    check_val("P_rst.fwd_k", {30'd0, hz_if.fwd_k}, 32'd0);
    hz_if.bus_wait = 1'b1;
    #1;
    check_val("P_rst.pc_hold", {31'd0, hz_if.pc_hold}, 32'd0);
    hz_if.bus_wait = 1'b0;
    #2 cpu_rst = 1'b1;
    tick();
    // Q: tags were discarded by reset
    expect_out("Q_after_rst", CTL_NONE, 2'b00, 2'b00, 2'b00);
`ifdef PIPE_HAZARD_PERF_EN
    check_val("Q.perf_stall",  perf_stall_cnt,  32'd0);
    check_val("Q.perf_flush",  perf_flush_cnt,  32'd0);
    check_val("Q.perf_freeze", perf_freeze_cnt, 32'd0);
`endif
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
